// File: rtl/pru_pkg.sv
// Shared types and constants for the PRU command queue.
package pru_pkg;

    typedef enum logic [1:0] {
        RECT   = 2'b00,
        CIRCLE = 2'b01,
        BITMAP = 2'b10
    } shape_t;

    // Word0 fields in bit order, so the word maps directly onto the struct.
    typedef struct packed {
        logic [1:0] shape;
        logic [1:0] color;
        logic [8:0] row;
        logic [9:0] col;
    } staging_t;

    // Shape is kept raw: encoding 2'b11 is a valid bitmap request.
    typedef struct packed {
        logic [1:0] shape;
        logic [1:0] color;
        logic [9:0] col;
        logic [8:0] row;
        logic [9:0] width;
        logic [8:0] height_radius;
    } pru_cmd_t;

    localparam logic [31:0] OFS_WORD0   = 32'h0;
    localparam logic [31:0] OFS_WORD1   = 32'h4;
    localparam logic [31:0] OFS_STATUS  = 32'h8;
    localparam logic [31:0] OFS_CONTROL = 32'hC;

    localparam int unsigned ST_FULL_BIT   = 8;
    localparam int unsigned ST_EMPTY_BIT  = 9;
    localparam int unsigned ST_OVF_BIT    = 10;
    localparam int unsigned ST_ACTIVE_BIT = 11;

    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_OVF_CLR_BIT = 1;

    // Combine the staged word0 fields with the word1 geometry.
    function automatic pru_cmd_t make_cmd(staging_t stage, logic [18:0] word1);
        pru_cmd_t cmd;
        cmd.shape         = stage.shape;
        cmd.color         = stage.color;
        cmd.col           = stage.col;
        cmd.row           = stage.row;
        cmd.width         = word1[9:0];
        cmd.height_radius = word1[18:10];
        return cmd;
    endfunction

endpackage

// File: rtl/pru_cmd_fifo.sv
// Synchronous command FIFO with push, pop and flush. Flush beats a same-cycle
// push; a push while full is rejected even if a pop frees a slot that cycle.
module pru_cmd_fifo
    import pru_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  pru_cmd_t      push_data,
    input  logic          pop,
    input  logic          flush,
    output pru_cmd_t      head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    pru_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // Next occupancy; flush empties the FIFO after any same-cycle pop.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count state; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pru_cmd_queue.sv
// CPU-facing command sequencer for the PRU: register decode, word0 staging,
// overflow flag, issuer FSM and the held PRU output fields.
module pru_cmd_queue
    import pru_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        pru_start,
    output logic [1:0]  pru_shape_select,
    output logic [1:0]  pru_color,
    output logic [9:0]  pru_col,
    output logic [8:0]  pru_row,
    output logic [9:0]  pru_width,
    output logic [8:0]  pru_height_radius,
    input  logic        pru_done,
    output logic        queue_empty,
    output logic        queue_full,
    output logic        idle
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StIssue    = 2'd1;
    localparam logic [1:0] StWaitDone = 2'd2;
    localparam logic [1:0] StRelease  = 2'd3;

    logic          sel_word0, sel_word1, sel_status, sel_control;
    logic          push_req, flush_req, ovf_clr;
    logic          pop;
    pru_cmd_t      push_cmd, head_cmd, cur_q;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    staging_t      staging_q;
    logic          ovf_q;
    logic [1:0]    state_q, state_d;
    logic          start_q, start_d;
    logic [31:0]   status, rdata_q;
    logic          unused_wdata;

    assign sel_word0   = (cpu_addr == BASE_ADDR + OFS_WORD0);
    assign sel_word1   = (cpu_addr == BASE_ADDR + OFS_WORD1);
    assign sel_status  = (cpu_addr == BASE_ADDR + OFS_STATUS);
    assign sel_control = (cpu_addr == BASE_ADDR + OFS_CONTROL);

    assign push_req  = cpu_we && sel_word1;
    assign flush_req = cpu_we && sel_control && cpu_wdata[CTRL_FLUSH_BIT];
    assign ovf_clr   = cpu_we && sel_control && cpu_wdata[CTRL_OVF_CLR_BIT];
    assign push_cmd  = make_cmd(staging_q, cpu_wdata[18:0]);

    assign unused_wdata = ^cpu_wdata[31:23];

    pru_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_cmd),
        .pop       (pop),
        .flush     (flush_req),
        .head      (head_cmd),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issuer next state: start is registered, so it rises one cycle after ISSUE.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                start_d = 1'b1;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (pru_done) begin
                    start_d = 1'b0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!pru_done) state_d = StIdle;
            end
            default: begin
                start_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // Issuer state, start level and the held command fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            if (pop) cur_q <= head_cmd;
        end
    end

    // Word0 staging and sticky overflow (a flushed push never overflows).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (cpu_we && sel_word0) staging_q <= staging_t'(cpu_wdata[22:0]);
            if (push_req && fifo_full && !flush_req) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Status word assembled from registered state only.
    always_comb begin
        status                = '0;
        status[7:0]           = 8'(fifo_count);
        status[ST_FULL_BIT]   = fifo_full;
        status[ST_EMPTY_BIT]  = fifo_empty;
        status[ST_OVF_BIT]    = ovf_q;
        status[ST_ACTIVE_BIT] = (state_q != StIdle);
    end

    // Registered read data, held between read strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (cpu_re) begin
            rdata_q <= sel_status ? status : 32'h0;
        end
    end

    assign cpu_rdata         = rdata_q;
    assign pru_start         = start_q;
    assign pru_shape_select  = cur_q.shape;
    assign pru_color         = cur_q.color;
    assign pru_col           = cur_q.col;
    assign pru_row           = cur_q.row;
    assign pru_width         = cur_q.width;
    assign pru_height_radius = cur_q.height_radius;
    assign queue_empty       = fifo_empty;
    assign queue_full        = fifo_full;
    assign idle              = fifo_empty && (state_q == StIdle);

endmodule
